// File: rtl/trim_pwm_capture.sv
// trim_pwm_capture: measures the high time and the period of one PWM input.
//
// The input passes through a 2-FF synchronizer and a 1-FF edge detector, so an input
// change is acted on at the third rising clock edge after it appears. Each complete
// period, from one accepted rising edge to the next, is published with a 1-cycle
// valid strobe. If the expected edge has not arrived by the time the counter reaches
// its maximum, a 1-cycle ovf strobe is raised instead and the block returns to idle.
//
// Optional feature: define TRIM_PWM_CAPTURE_FILTER_EN to insert a 3-sample stability
// filter after the synchronizer. It adds two cycles of edge latency and rejects pulses
// shorter than three cycles.
//
// Ports:
//   clock      in   1      component clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   en         in   1      enable; low aborts any measurement and returns to idle
//   pwm_in     in   1      asynchronous PWM input
//   high_time  out  R+1    sampled-high cycles of the last complete period
//   period     out  R+1    cycles between the last two accepted rising edges
//   valid      out  1      1-cycle strobe, high_time/period updated in the same cycle
//   ovf        out  1      1-cycle strobe when a required edge times out
module trim_pwm_capture #(
    parameter int unsigned Resolution = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                en,
    input  logic                pwm_in,
    output logic [Resolution:0] high_time,
    output logic [Resolution:0] period,
    output logic                valid,
    output logic                ovf
);

    localparam int unsigned CntW = Resolution + 1;
    localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne = {{(CntW-1){1'b0}}, 1'b1};

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHigh = 2'd1;
    localparam logic [1:0] StLow  = 2'd2;

    // Input conditioning. These flops are pure data pipeline: they run regardless of
    // en and are not reset, so a level that is already high when the FSM returns to
    // idle never shows up as a fresh rising edge.
    logic sync1_q, sync2_q;
    logic lvl, lvl_q;
    logic rise, fall;

    always_ff @(posedge clock) begin
        sync1_q <= pwm_in;
        sync2_q <= sync1_q;
    end

`ifdef TRIM_PWM_CAPTURE_FILTER_EN
    logic hist1_q, hist2_q;

    always_ff @(posedge clock) begin
        hist1_q <= sync2_q;
        hist2_q <= hist1_q;
    end

    // A new level is accepted only once three consecutive samples agree; otherwise
    // the previously accepted level (held in lvl_q) is kept.
    assign lvl = ((sync2_q == hist1_q) && (hist1_q == hist2_q)) ? sync2_q : lvl_q;
`else
    assign lvl = sync2_q;
`endif

    always_ff @(posedge clock) begin
        lvl_q <= lvl;
    end

    assign rise = lvl & ~lvl_q;
    assign fall = ~lvl & lvl_q;

    // Measurement FSM
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CntW-1:0] high_time_q, high_time_d;
    logic [CntW-1:0] period_q, period_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_cnt_d    = hi_cnt_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        ovf_d       = 1'b0;

        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        cnt_d   = CntOne;
                        state_d = StHigh;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        // The falling-edge cycle itself belongs to the low phase.
                        hi_cnt_d = cnt_q;
                        cnt_d    = cnt_q + 1'b1;
                        state_d  = StLow;
                    end else if (cnt_q == CntMax) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StLow: begin
                    if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_cnt_q;
                        valid_d     = 1'b1;
                        cnt_d       = CntOne;
                        state_d     = StHigh;
                    end else if (cnt_q == CntMax) begin
                        ovf_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hi_cnt_q    <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign ovf       = ovf_q;

endmodule
